intersection_phase_scheduler: RTL and testbench
===============================================

# intersection_phase_scheduler

Phase scheduler for a highway / farm-road intersection with a pedestrian crossing. It grants the intersection to one of three users: highway traffic (default owner), farm-road traffic (via `farm_sensor`) and pedestrians (via `ped_req`). It sequences the lights through yellow and all-red clearance phases. When farm and pedestrian requests compete, it arbitrates round-robin. It replaces the fixed-cycle highway/farm light sequencer at the top of the traffic design.

## Interface
- `HWY_MIN_GREEN`, 16: minimum highway-green cycles.
- `FARM_MIN_GREEN`, 4: minimum farm-green cycles.
- `FARM_MAX_GREEN`, 12: maximum farm-green cycles.
- `YELLOW_CYC`, 3: yellow duration, both roads.
- `ALL_RED_CYC`, 2: all-red clearance duration.
- `WALK_CYC`, 6: pedestrian walk duration.
- `CNT_W`, 8: phase timer width. All durations are ≥1 and < 2^CNT_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `farm_sensor` in 1: farm-road vehicle present (level).
- `ped_req` in 1: pedestrian button (pulse or level).
- `highway_red`, `highway_yellow`, `highway_green` out 1 each: highway lamps.
- `farm_red`, `farm_yellow`, `farm_green` out 1 each: farm lamps.
- `walk` out 1: pedestrian walk lamp.
- `ped_ack` out 1: one-cycle pulse when a pedestrian request is served.
- `phase` out 3: current state encoding.

## Operation
States (Moore; all lamps decode from the state register only):
- HWY_GREEN: hg, fr.
- HWY_YELLOW: hy, fr.
- ALL_RED_A: hr, fr.
- FARM_GREEN: hr, fg.
- FARM_YELLOW: hr, fy.
- PED_WALK: hr, fr, walk.
- ALL_RED_B: hr, fr.

Exactly one lamp per road is on in every state.

Reset values:
- State HWY_GREEN: `highway_green`=1, `farm_red`=1, every other lamp 0.
- `walk`=0, `ped_ack`=0, `phase`=0.
- Timer 0, `ped_pending`=0, `last_grant`=PED (so farm wins the first tie).

Timer:
- Clears to 0 on every state change; otherwise increments, saturating at all-ones.
- "Timer done(N)" means timer == N−1.

Pedestrian request latch:
- `ped_pending` sets on any cycle with `ped_req`=1.
- It clears on the cycle that transitions into PED_WALK. A `ped_req` sampled on that same edge is absorbed (clear wins).
- A `ped_req` during PED_WALK or later sets it again.

Transitions:
- HWY_GREEN → HWY_YELLOW when done(HWY_MIN_GREEN) or later, and (`farm_sensor` or `ped_pending`).
  - Latch `grant` on that edge. With only one requester, grant it.
  - With both requesting, grant the one opposite `last_grant`, then set `last_grant` = grant.
  - With no requester, stay indefinitely.
- HWY_YELLOW → ALL_RED_A at done(YELLOW_CYC).
- ALL_RED_A → FARM_GREEN or PED_WALK (per `grant`) at done(ALL_RED_CYC).
- FARM_GREEN → FARM_YELLOW at either:
  - done(FARM_MAX_GREEN); or
  - `farm_sensor`=0 with timer ≥ FARM_MIN_GREEN−1.

  A sensor drop before the minimum is ignored. If FARM_MIN_GREEN > FARM_MAX_GREEN, the maximum wins.
- FARM_YELLOW → ALL_RED_B at done(YELLOW_CYC).
- PED_WALK → ALL_RED_B at done(WALK_CYC). `ped_ack`=1 on the first PED_WALK cycle only.
- ALL_RED_B → HWY_GREEN at done(ALL_RED_CYC).

Other rules:
- `farm_sensor` is not latched. If it drops during HWY_YELLOW or ALL_RED_A, the committed farm grant still completes, with a FARM_MIN_GREEN phase.
- Reset asserted mid-phase returns all outputs to reset values immediately (asynchronous). `ped_pending` and `last_grant` are lost.

## Timing
- Input-to-decision latency: one edge. A request sampled at edge k, with minimum green met, makes `highway_yellow` visible after edge k.
- Phase lengths are exact in cycles: yellow = YELLOW_CYC, all-red = ALL_RED_CYC, walk = WALK_CYC.
- `farm_sensor` and `ped_req` are synchronous to `clk`; external synchronisers are the integrator's responsibility.

## Structure
- Package `traffic_pkg`:
  - `phase_e` enum: HWY_GREEN=0, HWY_YELLOW=1, ALL_RED_A=2, FARM_GREEN=3, FARM_YELLOW=4, PED_WALK=5, ALL_RED_B=6.
  - `grant_e` {FARM, PED}.
  - Lamp-vector struct type.
- Sub-module `phase_timer`: CNT_W counter with synchronous clear, saturation and `done(N)` compare; instantiated once.
- FSM, arbiter and request latch stay in the top module.

## Test plan
Counts below use default parameters and cycles after the reset release edge.

1. Idle: no requests for 100 cycles → HWY_GREEN held throughout; `highway_green`=1, `farm_red`=1, `walk`=0.
2. Farm request: `farm_sensor`=1 from reset, dropping at cycle 25 → phases in order:
   - highway green 16
   - highway yellow 3
   - all-red 2
   - farm green until the sensor drop (≤12)
   - farm yellow 3
   - all-red 2
   - then back to highway green
3. Farm stays: `farm_sensor` held high → farm green lasts exactly 12 cycles. A sensor drop after only 1 farm-green cycle → farm green lasts exactly 4 cycles.
4. Pedestrian: one-cycle `ped_req` at cycle 3 → PED_WALK entered after 16+3+2 cycles; `ped_ack` pulses once; `walk`=1 for exactly 6 cycles; all vehicle lamps red during the walk.
5. Contention: `farm_sensor` and `ped_req` both held → FARM, PED and FARM are served on successive highway exits (round-robin), with a full HWY_MIN_GREEN between grants.
6. Reset mid-operation: assert `reset` low mid-FARM_GREEN with `ped_pending`=1 → outputs reach reset values without waiting for a clock edge; after release, no walk occurs without a new `ped_req`.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler: phase and grant
// encodings, the lamp vector, and the phase-to-lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    ALL_RED_A   = 3'd2,
    FARM_GREEN  = 3'd3,
    FARM_YELLOW = 3'd4,
    PED_WALK    = 3'd5,
    ALL_RED_B   = 3'd6
  } phase_e;

  typedef enum logic {
    FARM = 1'b0,
    PED  = 1'b1
  } grant_e;

  typedef struct packed {
    logic hr;
    logic hy;
    logic hg;
    logic fr;
    logic fy;
    logic fg;
    logic walk;
  } lamps_t;

  // Unknown encodings fall back to all-red so no road ever sees green by accident.
  function automatic lamps_t phase_lamps(input phase_e p);
    lamps_t l;
    l = 7'b0000000;
    case (p)
      HWY_GREEN:   begin l.hg = 1'b1; l.fr = 1'b1; end
      HWY_YELLOW:  begin l.hy = 1'b1; l.fr = 1'b1; end
      ALL_RED_A:   begin l.hr = 1'b1; l.fr = 1'b1; end
      FARM_GREEN:  begin l.hr = 1'b1; l.fg = 1'b1; end
      FARM_YELLOW: begin l.hr = 1'b1; l.fy = 1'b1; end
      PED_WALK:    begin l.hr = 1'b1; l.fr = 1'b1; l.walk = 1'b1; end
      ALL_RED_B:   begin l.hr = 1'b1; l.fr = 1'b1; end
      default:     begin l.hr = 1'b1; l.fr = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on phase change, saturates, and reports
// done(N) (count == N-1) and min_met (count >= N-1) against two targets.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] done_n,
  input  logic [W-1:0] min_n,
  output logic         done,
  output logic         min_met
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear on phase change, otherwise increment and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (count_q == {W{1'b1}}) begin
      count_d = count_q;
    end else begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done    = (count_q == (done_n - W'(1)));
  assign min_met = (count_q >= (min_n - W'(1)));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Highway/farm-road/pedestrian phase scheduler: Moore FSM with yellow and
// all-red clearance, a pedestrian request latch and a round-robin tie-break.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int HWY_MIN_GREEN  = 16,
  parameter int FARM_MIN_GREEN = 4,
  parameter int FARM_MAX_GREEN = 12,
  parameter int YELLOW_CYC     = 3,
  parameter int ALL_RED_CYC    = 2,
  parameter int WALK_CYC       = 6,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       farm_sensor,
  input  logic       ped_req,
  output logic       highway_red,
  output logic       highway_yellow,
  output logic       highway_green,
  output logic       farm_red,
  output logic       farm_yellow,
  output logic       farm_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  phase_e state_q, state_d;
  grant_e grant_q, grant_d;
  grant_e last_grant_q, last_grant_d;
  logic   ped_pending_q, ped_pending_d;
  lamps_t lamps_q, lamps_d;
  logic   ped_ack_q, ped_ack_d;

  logic [CNT_W-1:0] done_n, min_n;
  logic timer_done, timer_min_met, timer_clr;
  logic ped_active, walk_entry;

  // Timer targets for the current phase; min_n only matters in the two greens.
  always_comb begin
    done_n = CNT_W'(HWY_MIN_GREEN);
    min_n  = CNT_W'(HWY_MIN_GREEN);
    case (state_q)
      HWY_GREEN:   begin done_n = CNT_W'(HWY_MIN_GREEN);  min_n = CNT_W'(HWY_MIN_GREEN);  end
      HWY_YELLOW:  begin done_n = CNT_W'(YELLOW_CYC);     min_n = CNT_W'(YELLOW_CYC);     end
      ALL_RED_A:   begin done_n = CNT_W'(ALL_RED_CYC);    min_n = CNT_W'(ALL_RED_CYC);    end
      FARM_GREEN:  begin done_n = CNT_W'(FARM_MAX_GREEN); min_n = CNT_W'(FARM_MIN_GREEN); end
      FARM_YELLOW: begin done_n = CNT_W'(YELLOW_CYC);     min_n = CNT_W'(YELLOW_CYC);     end
      PED_WALK:    begin done_n = CNT_W'(WALK_CYC);       min_n = CNT_W'(WALK_CYC);       end
      ALL_RED_B:   begin done_n = CNT_W'(ALL_RED_CYC);    min_n = CNT_W'(ALL_RED_CYC);    end
      default:     begin done_n = CNT_W'(ALL_RED_CYC);    min_n = CNT_W'(ALL_RED_CYC);    end
    endcase
  end

  phase_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (timer_clr),
    .done_n  (done_n),
    .min_n   (min_n),
    .done    (timer_done),
    .min_met (timer_min_met)
  );

  // Next-state, arbitration and request-latch logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ped_active   = ped_pending_q | ped_req;
    case (state_q)
      HWY_GREEN: begin
        if (timer_min_met && (farm_sensor || ped_active)) begin
          state_d = HWY_YELLOW;
          if (farm_sensor && ped_active) begin
            grant_d      = (last_grant_q == PED) ? FARM : PED;
            last_grant_d = grant_d;
          end else if (farm_sensor) begin
            grant_d = FARM;
          end else begin
            grant_d = PED;
          end
        end else begin
          state_d = HWY_GREEN;
        end
      end
      HWY_YELLOW:  state_d = timer_done ? ALL_RED_A : HWY_YELLOW;
      ALL_RED_A: begin
        if (timer_done) begin
          state_d = (grant_q == FARM) ? FARM_GREEN : PED_WALK;
        end else begin
          state_d = ALL_RED_A;
        end
      end
      // The max check is first so a min above max cannot stretch the phase.
      FARM_GREEN: begin
        if (timer_done || (!farm_sensor && timer_min_met)) begin
          state_d = FARM_YELLOW;
        end else begin
          state_d = FARM_GREEN;
        end
      end
      FARM_YELLOW: state_d = timer_done ? ALL_RED_B : FARM_YELLOW;
      PED_WALK:    state_d = timer_done ? ALL_RED_B : PED_WALK;
      ALL_RED_B:   state_d = timer_done ? HWY_GREEN : ALL_RED_B;
      default:     state_d = ALL_RED_B;
    endcase
    timer_clr     = (state_d != state_q);
    walk_entry    = (state_d == PED_WALK) && (state_q != PED_WALK);
    ped_pending_d = walk_entry ? 1'b0 : ped_active;
    ped_ack_d     = walk_entry;
    lamps_d       = phase_lamps(state_d);
  end

  // State, arbitration and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HWY_GREEN;
      grant_q       <= FARM;
      last_grant_q  <= PED;
      ped_pending_q <= 1'b0;
      lamps_q       <= phase_lamps(HWY_GREEN);
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      ped_pending_q <= ped_pending_d;
      lamps_q       <= lamps_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign highway_red    = lamps_q.hr;
  assign highway_yellow = lamps_q.hy;
  assign highway_green  = lamps_q.hg;
  assign farm_red       = lamps_q.fr;
  assign farm_yellow    = lamps_q.fy;
  assign farm_green     = lamps_q.fg;
  assign walk           = lamps_q.walk;
  assign ped_ack        = ped_ack_q;
  assign phase          = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus random
// sensor/button traffic checked every cycle against a behavioural model.
module tb_intersection_phase_scheduler;

  localparam int HMIN = 16, FMIN = 4, FMAX = 12, YC = 3, ARC = 2, WC = 6;

  logic clk = 1'b0, reset = 1'b0, farm_sensor = 1'b0, ped_req = 1'b0;
  logic highway_red, highway_yellow, highway_green;
  logic farm_red, farm_yellow, farm_green, walk, ped_ack;
  logic [2:0] phase;

  int total = 0, bad = 0;

  // model state: phase number, cycles spent in it, pending button, arbitration
  int m_ph, m_age, m_grant, m_last;
  bit m_pend, m_ack;

  intersection_phase_scheduler #(
    .HWY_MIN_GREEN(HMIN), .FARM_MIN_GREEN(FMIN), .FARM_MAX_GREEN(FMAX),
    .YELLOW_CYC(YC), .ALL_RED_CYC(ARC), .WALK_CYC(WC), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .farm_sensor(farm_sensor), .ped_req(ped_req),
    .highway_red(highway_red), .highway_yellow(highway_yellow),
    .highway_green(highway_green), .farm_red(farm_red),
    .farm_yellow(farm_yellow), .farm_green(farm_green),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // lamps packed as {hr,hy,hg,fr,fy,fg,walk}
  function automatic int exp_lamps(input int ph);
    case (ph)
      0: return 7'b0011000;
      1: return 7'b0101000;
      2: return 7'b1001000;
      3: return 7'b1000010;
      4: return 7'b1000100;
      5: return 7'b1001001;
      6: return 7'b1001000;
      default: return 7'b1001000;
    endcase
  endfunction

  function automatic int got_lamps();
    return int'({highway_red, highway_yellow, highway_green,
                 farm_red, farm_yellow, farm_green, walk});
  endfunction

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_grant = 0; m_last = 1; m_pend = 1'b0; m_ack = 1'b0;
  endtask

  // One rising edge of the reference scheduler (0=FARM, 1=PED for grants).
  task automatic model_step(input bit fs, input bit pr);
    int nxt;
    bit pa;
    pa  = m_pend | pr;
    nxt = m_ph;
    case (m_ph)
      0: if (m_age >= HMIN - 1 && (fs || pa)) begin
           if (fs && pa) begin
             m_grant = (m_last == 1) ? 0 : 1;
             m_last  = m_grant;
           end else begin
             m_grant = fs ? 0 : 1;
           end
           nxt = 1;
         end
      1: if (m_age == YC - 1) nxt = 2;
      2: if (m_age == ARC - 1) nxt = (m_grant == 0) ? 3 : 5;
      3: if (m_age == FMAX - 1 || (!fs && m_age >= FMIN - 1)) nxt = 4;
      4: if (m_age == YC - 1) nxt = 6;
      5: if (m_age == WC - 1) nxt = 6;
      6: if (m_age == ARC - 1) nxt = 0;
      default: nxt = 6;
    endcase
    m_ack  = (nxt == 5 && m_ph != 5);
    m_pend = m_ack ? 1'b0 : pa;
    m_age  = (nxt != m_ph) ? 0 : ((m_age < 255) ? m_age + 1 : 255);
    m_ph   = nxt;
  endtask

  task automatic check_outputs();
    check_val("lamps", got_lamps(), exp_lamps(m_ph));
    check_val("ped_ack", int'(ped_ack), int'(m_ack));
    check_val("phase", int'(phase), m_ph);
  endtask

  // Called just after a negedge; drives inputs, steps through one edge, checks.
  task automatic cycle(input bit fs, input bit pr);
    farm_sensor = fs;
    ped_req     = pr;
    @(posedge clk);
    model_step(fs, pr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0; farm_sensor = 1'b0; ped_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    int walk_cnt, ack_cnt, first_walk, ngr, steps;
    int grants[3];
    int prev;
    bit fs;
    model_reset();
    @(negedge clk);
    do_reset();

    // idle: highway keeps the intersection
    for (int c = 0; c < 100; c++) cycle(1'b0, 1'b0);
    check_val("idle_hold", int'(phase), 0);

    // pedestrian pulse at cycle 3
    do_reset();
    walk_cnt = 0; ack_cnt = 0; first_walk = -1;
    for (int c = 0; c < 45; c++) begin
      cycle(1'b0, c == 3);
      if (walk) begin
        walk_cnt++;
        if (first_walk < 0) first_walk = c;
      end
      if (ped_ack) ack_cnt++;
    end
    check_val("walk_len", walk_cnt, WC);
    check_val("ack_pulses", ack_cnt, 1);
    check_val("walk_start", first_walk, HMIN + YC + ARC - 1);

    // contention: both held, grants must alternate starting with farm
    do_reset();
    ngr = 0; prev = 0;
    for (int c = 0; c < 150; c++) begin
      cycle(1'b1, 1'b1);
      if (int'(phase) != prev && (phase == 3'd3 || phase == 3'd5) && ngr < 3) begin
        grants[ngr] = (phase == 3'd3) ? 0 : 1;
        ngr++;
      end
      prev = int'(phase);
    end
    check_val("rr_count", ngr, 3);
    if (ngr == 3) begin
      check_val("rr_g0", grants[0], 0);
      check_val("rr_g1", grants[1], 1);
      check_val("rr_g2", grants[2], 0);
    end

    // randomized traffic
    do_reset();
    fs = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19, 0) == 0) fs = ~fs;
      cycle(fs, $urandom_range(29, 0) == 0);
    end

    // asynchronous reset mid farm green with a pedestrian pending
    do_reset();
    cycle(1'b1, 1'b1);
    steps = 0;
    while (m_ph != 3 && steps < 100) begin
      cycle(1'b1, 1'b0);
      steps++;
    end
    check_val("reach_farm_green", int'(phase), 3);
    cycle(1'b1, 1'b0);
    check_val("ped_pending_model", int'(m_pend), 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_lamps", got_lamps(), 7'b0011000);
    check_val("async_phase", int'(phase), 0);
    check_val("async_ack", int'(ped_ack), 0);
    model_reset();
    farm_sensor = 1'b0;
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    walk_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      cycle(1'b0, 1'b0);
      if (walk) walk_cnt++;
    end
    check_val("no_walk_after_reset", walk_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
